// File: rtl/shift_seq_pkg.sv
// Shared definitions for shift_sequencer: FSM state encoding and the default
// width of the shift-count field.
package shift_seq_pkg;

  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// shift_sequencer: runs one load-and-shift operation on a 4-bit ShiftRegister
// per accepted request and reports the register contents on completion.
//
// Ports:
//   C            clock, rising edge
//   R            asynchronous active-high reset
//   start        request strobe, sampled only while busy=0
//   start_data   word loaded into the register
//   start_rtl    shift direction, forwarded to SR_RTL
//   start_count  number of shift cycles following the load
//   start_fill   bit shifted in during the shift cycles
//   busy         high in LOAD, SHIFT and DONE
//   done         one-cycle completion pulse (first IDLE cycle)
//   result       SR_Q captured at completion, held until the next completion
//   SR_L/SR_RTL/SR_D  register control pins (all registered)
//   SR_Q         register output feedback
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after an operation
// LOAD  | SR_L=1, SR_D=latched data
// SHIFT | SR_L=0, SR_D={4{fill}}, one shift per cycle, cnt counts down to 0
// DONE  | capture SR_Q into result at the exiting edge
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic [3:0]       start_data,
  input  logic             start_rtl,
  input  logic [CNT_W-1:0] start_count,
  input  logic             start_fill,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             SR_L,
  output logic             SR_RTL,
  output logic [3:0]       SR_D,
  input  logic [3:0]       SR_Q
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] count_q;
  logic             fill_q;

  assign busy = (state != IDLE);

  // Control pins are registered alongside the state so that each pin value
  // is present during the cycle whose closing edge the register acts on.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state   <= IDLE;
      cnt     <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      done    <= 1'b0;
      result  <= 4'b0000;
      SR_L    <= 1'b0;
      SR_RTL  <= 1'b0;
      SR_D    <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count_q <= start_count;
            fill_q  <= start_fill;
            SR_L    <= 1'b1;
            SR_D    <= start_data;
            SR_RTL  <= start_rtl;
            state   <= LOAD;
          end
        end
        LOAD: begin
          SR_L <= 1'b0;
          if (count_q == '0) begin
            SR_D  <= 4'b0000;
            state <= DONE;
          end else begin
            cnt   <= count_q;
            SR_D  <= {4{fill_q}};
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            SR_D  <= 4'b0000;
            state <= DONE;
          end
        end
        DONE: begin
          result <= SR_Q;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer with a behavioural 4-bit ShiftRegister on
// the SR_* pins and an arithmetic reference for the expected result.
module tb_shift_sequencer;

  localparam int CW = 3;

  logic          C = 1'b0;
  logic          R = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    start_data = 4'h0;
  logic          start_rtl = 1'b0;
  logic [CW-1:0] start_count = '0;
  logic          start_fill = 1'b0;
  logic          busy, done, SR_L, SR_RTL;
  logic [3:0]    result, SR_D;
  logic [3:0]    sr_q = 4'h0;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.CNT_W(CW)) dut (
    .C(C), .R(R), .start(start), .start_data(start_data),
    .start_rtl(start_rtl), .start_count(start_count), .start_fill(start_fill),
    .busy(busy), .done(done), .result(result),
    .SR_L(SR_L), .SR_RTL(SR_RTL), .SR_D(SR_D), .SR_Q(sr_q)
  );

  always #5 C = ~C;

  // ShiftRegister: load on L; RTL=1 shifts toward MSB taking D[0],
  // RTL=0 shifts toward LSB taking D[3].
  always @(posedge C) begin
    if (SR_L) sr_q <= SR_D;
    else if (SR_RTL) sr_q <= {sr_q[2:0], SR_D[0]};
    else sr_q <= {SR_D[3], sr_q[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  function automatic logic [31:0] exp_result(input int d, input bit rtl, input int n, input bit f);
    int r;
    if (n >= 4) return f ? 32'hF : 32'h0;
    if (rtl) r = ((d << n) & 15) | (f ? ((1 << n) - 1) : 0);
    else     r = (d >> n) | (f ? (15 & ~(15 >> n)) : 0);
    return 32'(r);
  endfunction

  task automatic drive(input logic [3:0] d, input bit r, input int n, input bit f);
    start_data  = d;
    start_rtl   = r;
    start_count = CW'(n);
    start_fill  = f;
    start       = 1'b1;
  endtask

  // Called at the sample point just after the accepting edge.
  task automatic follow_op(input logic [3:0] d, input bit r, input int n, input bit f,
                           input bit hold, input bit pulse, input bit scramble);
    int k = 0;
    int lcnt = 0;
    int bcnt = 0;
    bit seen = 0;
    check("load_l", 32'(SR_L), 1);
    check("load_d", 32'(SR_D), 32'(d));
    check("load_rtl", 32'(SR_RTL), 32'(r));
    if (!hold) start = 1'b0;
    if (scramble) begin
      start_data  = 4'($urandom);
      start_count = CW'($urandom);
      start_fill  = 1'($urandom);
      start_rtl   = 1'($urandom);
    end
    while (k < 40) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (SR_L) lcnt++;
      if (busy) bcnt++;
      if (k == 1 && n > 0) begin
        check("shift_d", 32'(SR_D), f ? 32'hF : 32'h0);
        check("shift_rtl", 32'(SR_RTL), 32'(r));
      end
      if (!hold && pulse) start = (k >= 1 && k <= n) ? 1'($urandom) : 1'b0;
      step();
      k++;
    end
    check("done_seen", 32'(seen), 1);
    if (seen) begin
      check("latency", 32'(k), 32'(n + 2));
      check("load_cycles", 32'(lcnt), 1);
      check("busy_cycles", 32'(bcnt), 32'(n + 2));
      check("result", 32'(result), exp_result(int'(d), r, n, f));
      check("busy_at_done", 32'(busy), 0);
    end
    if (!hold) begin
      start = 1'b0;
      step();
      check("done_width", 32'(done), 0);
    end
  endtask

  task automatic run_op(input logic [3:0] d, input bit r, input int n, input bit f,
                        input bit pulse, input bit scramble);
    drive(d, r, n, f);
    step();
    follow_op(d, r, n, f, 1'b0, pulse, scramble);
  endtask

  initial begin
    int dcnt;
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_sr_l", 32'(SR_L), 0);
    check("rst_sr_rtl", 32'(SR_RTL), 0);
    check("rst_sr_d", 32'(SR_D), 0);
    #2 R = 1'b0;
    step();

    // count = 0
    run_op(4'b1011, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    // reset mid-SHIFT with count = 5
    drive(4'b0110, 1'b0, 5, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 1);
    #2 R = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_result", 32'(result), 0);
    check("mid_rst_sr_l", 32'(SR_L), 0);
    check("mid_rst_sr_rtl", 32'(SR_RTL), 0);
    check("mid_rst_sr_d", 32'(SR_D), 0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dcnt++;
    end
    #2 R = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dcnt++;
    end
    check("no_done_after_rst", 32'(dcnt), 0);
    check("post_rst_busy", 32'(busy), 0);

    // fill to ones, both directions; fill to zeros with count 7
    run_op(4'b0000, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    run_op(4'b0000, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    run_op(4'b1111, 1'b0, 7, 1'b0, 1'b0, 1'b0);

    // start pulses during SHIFT ignored, exactly one done
    run_op(4'b1001, 1'b1, 3, 1'b0, 1'b1, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcnt++;
      step();
    end
    check("extra_done", 32'(dcnt), 0);
    check("idle_busy", 32'(busy), 0);

    // start held high: back-to-back, no idle gap
    drive(4'b1100, 1'b0, 2, 1'b1);
    step();
    follow_op(4'b1100, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    start_data  = 4'b0011;
    start_rtl   = 1'b1;
    start_count = CW'(1);
    start_fill  = 1'b0;
    step();
    check("b2b_busy", 32'(busy), 1);
    follow_op(4'b0011, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // randomized operations with input scrambling and ignored start pulses
    for (int i = 0; i < 24; i++) begin
      logic [3:0] d;
      bit r, f;
      int n;
      d = 4'($urandom);
      r = 1'($urandom);
      f = 1'($urandom);
      n = int'($urandom_range(0, (1 << CW) - 1));
      run_op(d, r, n, f, 1'($urandom), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
